// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_defs: shared encodings for the pipeline sequencing controller.
//   ctrl_state_e  - FSM state encoding (also exported on state_o for debug)
//   BUBBLE_ALU_FN - ALU function code the ID/EX register loads when a bubble
//                   is inserted (stall=1)
package pipe_ctrl_defs;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] BUBBLE_ALU_FN = 5'h1F;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the pipeline datapath and the
// sequencing controller.
//   master - datapath side: drives ID/EX hazard info and mem_busy, consumes
//            the hold/flush/stall/freeze controls
//   slave  - controller side
interface pipe_hazard_ctrl_if;
  logic [2:0] ID_rs_addr;
  logic [2:0] ID_rt_addr;
  logic       ID_uses_rs;
  logic       ID_uses_rt;
  logic       ID_halt;
  logic [2:0] EX_rd_addr;
  logic       EX_reg_write;
  logic       EX_mem_read;
  logic       EX_redirect;
  logic       mem_busy;
  logic       pc_hold;
  logic       IF_ID_hold;
  logic       IF_ID_flush;
  logic       stall;
  logic       pipe_freeze;
  logic       halt_done;
  logic       mem_timeout;
  logic [1:0] state_o;

  modport master (
    output ID_rs_addr, ID_rt_addr, ID_uses_rs, ID_uses_rt, ID_halt,
           EX_rd_addr, EX_reg_write, EX_mem_read, EX_redirect, mem_busy,
    input  pc_hold, IF_ID_hold, IF_ID_flush, stall, pipe_freeze,
           halt_done, mem_timeout, state_o
  );

  modport slave (
    input  ID_rs_addr, ID_rt_addr, ID_uses_rs, ID_uses_rt, ID_halt,
           EX_rd_addr, EX_reg_write, EX_mem_read, EX_redirect, mem_busy,
    output pc_hold, IF_ID_hold, IF_ID_flush, stall, pipe_freeze,
           halt_done, mem_timeout, state_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: combinational load-use detector.
//   rs_addr/rt_addr, uses_rs/uses_rt - source operands of the ID instruction
//   ex_rd_addr, ex_reg_write, ex_mem_read - producer currently in EX
//   load_use - ID needs a value that the EX load has not yet fetched
// A MEM-stage producer is deliberately not checked: forwarding covers it.
module hazard_cmp (
  input  logic [2:0] rs_addr,
  input  logic [2:0] rt_addr,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic [2:0] ex_rd_addr,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  output logic       load_use
);
  logic rs_hit, rt_hit;

  assign rs_hit   = uses_rs && (rs_addr == ex_rd_addr);
  assign rt_hit   = uses_rt && (rt_addr == ex_rd_addr);
  assign load_use = ex_mem_read && ex_reg_write && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: advance/stall/flush/freeze decision for the five-stage
// pipeline, plus HALT drain sequencing.
//   clk - clock
//   rst - synchronous reset, active low
//   hz  - slave side of pipe_hazard_ctrl_if (hazard inputs, pipe controls,
//         sticky halt_done / mem_timeout, debug state_o)
// Priority: HALTED > mem_busy > EX_redirect > load-use > ID_halt.
module pipe_hazard_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int HALT_DRAIN_CYC = 3,
  parameter int MEM_WAIT_MAX   = 15,
  parameter int CNT_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(HALT_DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX   = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MEM_WAIT_MAX - 1);

  ctrl_state_e      state, eff_state;
  logic             ret_drain;   // MEMWAIT return target: 1=DRAIN, 0=RUN
  logic [CNT_W-1:0] drain_cnt, wait_cnt;
  logic             halt_done_q, timeout_q;
  logic             load_use;
  logic             pc_hold, if_id_hold, if_id_flush, stall, pipe_freeze;

  hazard_cmp u_cmp (
    .rs_addr      (hz.ID_rs_addr),
    .rt_addr      (hz.ID_rt_addr),
    .uses_rs      (hz.ID_uses_rs),
    .uses_rt      (hz.ID_uses_rt),
    .ex_rd_addr   (hz.EX_rd_addr),
    .ex_reg_write (hz.EX_reg_write),
    .ex_mem_read  (hz.EX_mem_read),
    .load_use     (load_use)
  );

  // Once memory releases, MEMWAIT behaves exactly like the state it froze.
  assign eff_state = (state == ST_MEMWAIT) ? (ret_drain ? ST_DRAIN : ST_RUN)
                                           : state;

  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    stall       = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      // everything low while in reset
    end else if (state == ST_HALTED) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (hz.mem_busy) begin
      // EX is not advancing, so no bubble and no flush this cycle
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (hz.EX_redirect) begin
      // wrong-path ID instruction becomes a bubble; PC takes the target
      if_id_flush = 1'b1;
      stall       = 1'b1;
    end else if (eff_state == ST_DRAIN) begin
      // ID holds only discarded fetches here, so its hazards are ignored
      pc_hold     = 1'b1;
      if_id_flush = 1'b1;
    end else if (load_use) begin
      stall       = 1'b1;
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      ret_drain   <= 1'b0;
      drain_cnt   <= '0;
      wait_cnt    <= '0;
      halt_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (state != ST_HALTED) begin
      if (hz.mem_busy) begin
        state <= ST_MEMWAIT;
        if (state != ST_MEMWAIT) ret_drain <= (state == ST_DRAIN);
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_LAST) timeout_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
        if (eff_state == ST_DRAIN) begin
          // a stray redirect during drain still flushes but keeps draining
          if (drain_cnt == DRAIN_LAST) begin
            state       <= ST_HALTED;
            halt_done_q <= 1'b1;
          end else begin
            state     <= ST_DRAIN;
            drain_cnt <= drain_cnt + 1'b1;
          end
        end else if (hz.ID_halt && !hz.EX_redirect && !load_use) begin
          state     <= ST_DRAIN;
          drain_cnt <= '0;
        end else begin
          state <= ST_RUN;
        end
      end
    end
  end

  assign hz.pc_hold     = pc_hold;
  assign hz.IF_ID_hold  = if_id_hold;
  assign hz.IF_ID_flush = if_id_flush;
  assign hz.stall       = stall;
  assign hz.pipe_freeze = pipe_freeze;
  assign hz.halt_done   = halt_done_q;
  assign hz.mem_timeout = timeout_q;
  assign hz.state_o     = state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(.HALT_DRAIN_CYC(3), .MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  // expected output vector: {pc_hold, IF_ID_hold, IF_ID_flush, stall, pipe_freeze}
  typedef struct {
    logic [2:0] rs, rt;
    logic       urs, urt, halt;
    logic [2:0] rd;
    logic       rw, mr, redir, busy;
    logic [4:0] exp;
    logic [1:0] nst;
    string      name;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [4:0] outs();
    return {hif.pc_hold, hif.IF_ID_hold, hif.IF_ID_flush, hif.stall, hif.pipe_freeze};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                       input logic urt, input logic halt, input logic [2:0] rd,
                       input logic rw, input logic mr, input logic redir, input logic busy);
    @(negedge clk);
    hif.ID_rs_addr   = rs;
    hif.ID_rt_addr   = rt;
    hif.ID_uses_rs   = urs;
    hif.ID_uses_rt   = urt;
    hif.ID_halt      = halt;
    hif.EX_rd_addr   = rd;
    hif.EX_reg_write = rw;
    hif.EX_mem_read  = mr;
    hif.EX_redirect  = redir;
    hif.mem_busy     = busy;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //          rs rt urs urt hlt rd rw mr rdr bsy  exp       nst
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'd0, "idle"};
    vecs[1]  = '{1, 3, 1, 1, 0, 1, 1, 1, 0, 0, 5'b11010, 2'd0, "lu_rs"};
    vecs[2]  = '{1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 2'd0, "lu_bubble_clears"};
    vecs[3]  = '{1, 3, 0, 0, 0, 1, 1, 1, 0, 0, 5'b00000, 2'd0, "lu_no_use"};
    vecs[4]  = '{2, 5, 1, 1, 0, 5, 1, 1, 0, 0, 5'b11010, 2'd0, "lu_rt"};
    vecs[5]  = '{5, 0, 1, 0, 0, 5, 0, 1, 0, 0, 5'b00000, 2'd0, "lu_no_regwrite"};
    vecs[6]  = '{5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 5'b00000, 2'd0, "alu_producer"};
    vecs[7]  = '{4, 6, 1, 1, 0, 7, 1, 1, 0, 0, 5'b00000, 2'd0, "rd_mismatch"};
    vecs[8]  = '{1, 3, 1, 1, 1, 1, 1, 1, 1, 0, 5'b00110, 2'd0, "redir_lu_halt"};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00110, 2'd0, "redir"};
    vecs[10] = '{1, 3, 1, 1, 0, 1, 1, 1, 1, 1, 5'b11001, 2'd1, "busy_over_all"};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'd0, "busy_release"};
    vecs[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5'b11001, 2'd1, "busy_over_halt"};
    vecs[13] = '{2, 0, 1, 0, 1, 2, 1, 1, 0, 0, 5'b11010, 2'd0, "lu_before_halt"};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'd0, "idle_end"};

    // reset state, with inputs that would otherwise assert controls
    drive(1, 3, 1, 1, 1, 1, 1, 1, 0, 1);
    chk("rst_outs", outs(), 0);
    tick();
    chk("rst_state", hif.state_o, 0);
    chk("rst_halt_done", hif.halt_done, 0);
    chk("rst_timeout", hif.mem_timeout, 0);
    @(negedge clk);
    rst = 1'b1;

    // combinational decisions from RUN
    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].halt,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].redir, vecs[i].busy);
      chk({vecs[i].name, "_outs"}, outs(), vecs[i].exp);
      tick();
      chk({vecs[i].name, "_state"}, hif.state_o, vecs[i].nst);
    end

    // HALT drain: halt_done exactly 3 cycles after HALT leaves ID
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("halt_entry_outs", outs(), 0);
    tick();
    chk("halt_entry_state", hif.state_o, 2);
    for (int c = 1; c <= 3; c++) begin
      idle();
      chk($sformatf("drain%0d_outs", c), outs(), 5'b10100);
      tick();
      chk($sformatf("drain%0d_halt_done", c), hif.halt_done, (c == 3) ? 1 : 0);
    end
    chk("halted_state", hif.state_o, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("halted_outs", outs(), 5'b11001);
    tick();
    chk("halted_sticky", hif.halt_done, 1);
    chk("halted_stays", hif.state_o, 3);

    // freeze during drain delays halt_done by the frozen cycles
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("frz%0d_outs", c), outs(), 5'b11001);
      tick();
      chk($sformatf("frz%0d_state", c), hif.state_o, 1);
      chk($sformatf("frz%0d_halt_done", c), hif.halt_done, 0);
    end
    idle();
    chk("frz_release_outs", outs(), 5'b10100);
    tick();
    chk("frz_release_state", hif.state_o, 2);
    chk("frz_release_halt_done", hif.halt_done, 0);
    idle();
    tick();
    chk("frz_halt_done", hif.halt_done, 1);

    // memory wait timeout after 15 consecutive busy cycles, sticky
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      if (c == 14) chk("timeout_at14", hif.mem_timeout, 0);
    end
    chk("timeout_at15", hif.mem_timeout, 1);
    idle();
    tick();
    chk("timeout_ret_state", hif.state_o, 0);
    chk("timeout_sticky", hif.mem_timeout, 1);

    // reset in the middle of DRAIN with mem_timeout set
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_state", hif.state_o, 2);
    idle();
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", outs(), 0);
    tick();
    chk("mid_rst_state", hif.state_o, 0);
    chk("mid_rst_halt_done", hif.halt_done, 0);
    chk("mid_rst_timeout", hif.mem_timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_outs", outs(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencing controller for the WiscSP13 five-stage pipeline. Each cycle it decides whether to advance, stall or flush:
- Detects load-use hazards and drives the bubble-insert `stall` into the ID/EX register.
- Flushes wrong-path instructions on EX redirects (taken branch, J/JR/JAL/JALR).
- Freezes the whole pipe while data memory is busy.
- Sequences the HALT drain and completion.

Parameters:
HALT_DRAIN_CYC, 3, cycles after HALT leaves ID before halt_done (EX, MEM, WB).
MEM_WAIT_MAX, 15, consecutive mem_busy cycles before mem_timeout sets.
CNT_W, 4, width of the drain and wait counters; must hold max(HALT_DRAIN_CYC, MEM_WAIT_MAX).

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-low.
ID_rs_addr  in  3  Rs field of the instruction in ID.
ID_rt_addr  in  3  Rt field of the instruction in ID.
ID_uses_rs  in  1  ID instruction reads Rs.
ID_uses_rt  in  1  ID instruction reads Rt.
ID_halt  in  1  ID instruction is HALT.
EX_rd_addr  in  3  destination register of the EX instruction.
EX_reg_write  in  1  EX instruction writes the register file.
EX_mem_read  in  1  EX instruction is a load.
EX_redirect  in  1  EX resolved a taken branch or any jump.
mem_busy  in  1  data memory not ready this cycle.
pc_hold  out  1  PC keeps its value.
IF_ID_hold  out  1  IF/ID register keeps its value.
IF_ID_flush  out  1  IF/ID loads a NOP.
stall  out  1  ID/EX loads a bubble (control zeroed, ALU_fn 5'h1F).
pipe_freeze  out  1  all pipeline registers hold.
halt_done  out  1  registered; sticky until reset.
mem_timeout  out  1  registered; sticky until reset.
state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst==0 at posedge): state RUN, counters 0, halt_done=0, mem_timeout=0.
  - While rst==0, all combinational outputs are forced 0.
- FSM states: RUN=0, MEMWAIT=1, DRAIN=2, HALTED=3.
  - MEMWAIT uses a 1-bit ret_state register that records RUN or DRAIN.
- Combinational priority, highest first: HALTED > mem_busy > EX_redirect > load-use > ID_halt.
- HALTED: pc_hold=IF_ID_hold=pipe_freeze=1, halt_done=1; all other outputs 0. Exit only by reset.
- Freeze: mem_busy=1 in any state except HALTED.
  - pipe_freeze=pc_hold=IF_ID_hold=1.
  - stall, IF_ID_flush forced 0, because EX is not advancing.
  - Next state is MEMWAIT; ret_state captures RUN or DRAIN.
  - Wait counter increments each MEMWAIT cycle and saturates.
  - When the counter reaches MEM_WAIT_MAX, mem_timeout sets.
  - On mem_busy==0: return to ret_state and clear the wait counter.
  - The drain counter does not advance while frozen.
- Redirect: EX_redirect=1 and not frozen.
  - IF_ID_flush=1 and stall=1 in the same cycle; the wrong-path ID instruction becomes a bubble.
  - pc_hold=0 so the PC takes the target.
  - Redirect overrides load-use.
  - A simultaneous ID_halt is squashed; no DRAIN entry.
  - Redirect while in DRAIN cannot occur architecturally; if it does, flush as above and stay in DRAIN.
- Load-use: EX_mem_read & EX_reg_write & ((ID_uses_rs & ID_rs_addr==EX_rd_addr) | (ID_uses_rt & ID_rt_addr==EX_rd_addr)).
  - stall=1, pc_hold=1, IF_ID_hold=1 for exactly one cycle; the bubble then sits in EX and the condition clears.
  - No stall for the MEM-stage producer; that case is covered by forwarding.
- Halt entry: RUN, ID_halt=1, no freeze/redirect/load-use.
  - HALT advances into ID/EX normally; next state DRAIN; drain counter cleared.
  - If load-use holds together with ID_halt, the stall is taken first and HALT is re-evaluated next cycle.
- DRAIN: pc_hold=1, IF_ID_flush=1 every cycle, so no new instructions enter.
  - Drain counter increments each unfrozen cycle.
  - When the counter equals HALT_DRAIN_CYC-1, the next state is HALTED.
  - halt_done rises HALT_DRAIN_CYC unfrozen cycles after HALT leaves ID.
- RUN with no event: all outputs 0.
- Reset mid-MEMWAIT or mid-DRAIN returns to RUN and clears both sticky flags.

Decomposition:
- Shared package/include `pipe_ctrl_defs`: state encodings, and bubble ALU_fn constant 5'h1F (shared with the ID/EX register).
- One sub-module, `hazard_cmp`: purely combinational load-use detect, reusable by the forwarding unit.
- Counters and the FSM stay in the top module and use the standard dff cells.

Test Plan:
- Load-use: lw r1 then add r2,r1,r3 (EX_mem_read=1, EX_rd=1, ID_rs=1) -> stall/pc_hold/IF_ID_hold high exactly 1 cycle; the same pair with ID_uses_rs=0 -> no stall.
- Redirect with load-use: EX_redirect=1 together with the load-use condition -> IF_ID_flush=1, stall=1, pc_hold=0; ID_halt in that cycle -> state stays RUN.
- Freeze: mem_busy high 4 cycles during DRAIN -> pipe_freeze=1 for 4 cycles, drain counter paused, halt_done delayed by 4 cycles; mem_busy high 15 cycles -> mem_timeout=1, sticky.
- Halt: ID_halt in RUN -> DRAIN; halt_done=1 exactly 3 cycles later; pc_hold stays 1 thereafter.
- Reset: rst=0 during DRAIN with mem_timeout=1 -> next cycle state_o=0, halt_done=0, mem_timeout=0, all outputs 0.
